// File: rtl/xif_mac_coproc.sv
// Multiply-accumulate coprocessor on the eXtension interface: speculative issue queue,
// commit/kill tracking and in-order execution of custom-0 MAC/RDACC/CLRACC.
module xif_mac_coproc #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [31:0]           issue_rs1_i,
  input  logic [31:0]           issue_rs2_i,
  input  logic [1:0]            issue_rs_valid_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [31:0]           result_data_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o,
  output logic [31:0]           acc_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [2:0]            funct3;
    logic [4:0]            rd;
    logic [31:0]           rs1;
    logic [31:0]           rs2;
    logic                  committed;
    logic                  killed;
  } entry_t;

  typedef enum logic [1:0] {StIdle, StExec, StResult} state_e;

  entry_t        fifo_q [DEPTH];
  entry_t        fifo_d [DEPTH];
  entry_t        ext    [DEPTH];
  entry_t        new_e;
  entry_t        head;
  logic [CW-1:0] count_q, count_d, n_cnt;
  logic          recognised, full, push, pop, found, head_valid, dup_id;
  state_e        state_q;
  logic          phase_q;
  logic [31:0]   prod_q, acc_q, mac_sum;
  logic          unused_instr;

  assign unused_instr = ^issue_instr_i[24:15];

  assign recognised = (issue_instr_i[6:0] == 7'b0001011) && (issue_instr_i[31:25] == 7'd0) &&
                      (issue_instr_i[14:12] <= 3'd2);
  assign full              = (count_q == CW'(DEPTH));
  assign issue_accept_o    = recognised;
  assign issue_writeback_o = recognised;
  assign issue_ready_o     = !recognised || (!full && issue_rs_valid_i == 2'b11);
  assign push              = issue_valid_i && issue_ready_o && recognised;
  assign acc_o             = acc_q;
  assign mac_sum           = acc_q + prod_q;

  // Queue view after this cycle's push and commit, so IDLE can react to a same-cycle commit.
  always_comb begin
    new_e           = '0;
    new_e.id        = issue_id_i;
    new_e.funct3    = issue_instr_i[14:12];
    new_e.rd        = issue_instr_i[11:7];
    new_e.rs1       = issue_rs1_i;
    new_e.rs2       = issue_rs2_i;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ext[i] = fifo_q[i];
      if (push && CW'(i) == count_q) ext[i] = new_e;
    end
    n_cnt = count_q + CW'(push);
    found = 1'b0;
    if (commit_valid_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!found && CW'(i) < n_cnt && ext[i].id == commit_id_i) begin
          ext[i].committed = 1'b1;
          if (commit_kill_i) ext[i].killed = 1'b1;
          found = 1'b1;
        end
      end
    end
    head       = ext[0];
    head_valid = (n_cnt != '0);
    pop = (state_q == StIdle && head_valid && head.committed && head.killed) ||
          (state_q == StResult && result_ready_i);
    for (int unsigned i = 0; i < DEPTH; i++) fifo_d[i] = ext[i];
    if (pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) fifo_d[i] = ext[i+1];
    end
    count_d = n_cnt - CW'(pop);
  end

  always_comb begin
    dup_id = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && fifo_q[i].id == issue_id_i) dup_id = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      phase_q        <= 1'b0;
      prod_q         <= '0;
      acc_q          <= '0;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_data_o  <= '0;
      result_rd_o    <= '0;
      result_we_o    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (head_valid && head.committed && !head.killed) begin
            state_q <= StExec;
            phase_q <= 1'b0;
          end
        end
        StExec: begin
          if (fifo_q[0].funct3 == 3'b000 && !phase_q) begin
            prod_q  <= fifo_q[0].rs1 * fifo_q[0].rs2;
            phase_q <= 1'b1;
          end else begin
            result_valid_o <= 1'b1;
            result_id_o    <= fifo_q[0].id;
            result_rd_o    <= fifo_q[0].rd;
            result_we_o    <= (fifo_q[0].rd != 5'd0);
            state_q        <= StResult;
            if (fifo_q[0].funct3 == 3'b000) begin
              acc_q         <= mac_sum;
              result_data_o <= mac_sum;
            end else begin
              result_data_o <= acc_q;
              if (fifo_q[0].funct3 == 3'b010) acc_q <= '0;
            end
          end
        end
        StResult: begin
          if (result_ready_i) begin
            result_valid_o <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Upstream keeps ids unique among outstanding entries.
  assert property (@(posedge clk_i) disable iff (rst_i) push |-> !dup_id)
    else $error("duplicate outstanding id");

endmodule

// File: tb/tb_xif_mac_coproc.sv
// Scoreboard bench for xif_mac_coproc: directed issue/commit vectors, monitor pops expectations.
module tb_xif_mac_coproc;
  logic        clk, rst;
  logic        issue_valid, issue_ready, issue_accept, issue_writeback;
  logic [31:0] issue_instr, issue_rs1, issue_rs2;
  logic [3:0]  issue_id, commit_id, res_id;
  logic [1:0]  issue_rs_valid;
  logic        commit_valid, commit_kill;
  logic        res_valid, rdy, res_we;
  logic [31:0] res_data, acc;
  logic [4:0]  res_rd;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  xif_mac_coproc #(.X_ID_WIDTH(4), .DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_instr_i(issue_instr),
    .issue_id_i(issue_id), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
    .issue_rs_valid_i(issue_rs_valid), .issue_accept_o(issue_accept),
    .issue_writeback_o(issue_writeback),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .result_valid_o(res_valid), .result_ready_i(rdy), .result_id_o(res_id),
    .result_data_o(res_data), .result_rd_o(res_rd), .result_we_o(res_we), .acc_o(acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [2:0] f3, input logic [4:0] rd);
    return {7'd0, 10'd0, f3, rd, 7'b0001011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic expect_res(input logic [3:0] id, input logic [31:0] d, input logic [4:0] rd);
    exp_t e;
    e.id = id; e.data = d; e.rd = rd; e.we = (rd != 5'd0);
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [3:0] id,
                       input logic [31:0] a, input logic [31:0] b, input logic cmt);
    @(posedge clk); #1;
    issue_valid = 1'b1; issue_instr = ins(f3, rd); issue_id = id;
    issue_rs1 = a; issue_rs2 = b; issue_rs_valid = 2'b11;
    commit_valid = cmt; commit_id = id; commit_kill = 1'b0;
    #1 chk("issue_ready", {31'd0, issue_ready}, 32'd1);
    @(posedge clk); #1;
    issue_valid = 1'b0; commit_valid = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    @(posedge clk); #1;
    commit_valid = 1'b1; commit_id = id; commit_kill = kill;
    @(posedge clk); #1;
    commit_valid = 1'b0; commit_kill = 1'b0;
  endtask

  task automatic drain;
    int i;
    for (i = 0; i < 80 && (sb.size() != 0 || res_valid); i++) @(negedge clk);
    if (sb.size() != 0 || res_valid) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending=%0d valid=%0b expected pending=0", sb.size(),
               res_valid);
    end
  endtask

  // Monitor: every accepted result is compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && rdy) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result: id=%0d data=%h expected no result", res_id, res_data);
      end else begin
        e = sb.pop_front();
        chk("res_id", {28'd0, res_id}, {28'd0, e.id});
        chk("res_data", res_data, e.data);
        chk("res_rd", {27'd0, res_rd}, {27'd0, e.rd});
        chk("res_we", {31'd0, res_we}, {31'd0, e.we});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: sim time exceeded, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1;
    issue_valid = 1'b0; issue_instr = '0; issue_id = '0; issue_rs1 = '0; issue_rs2 = '0;
    issue_rs_valid = 2'b00; commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_acc", acc, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_ready_unrec", {31'd0, issue_ready}, 32'd1);
    chk("rst_accept_unrec", {31'd0, issue_accept}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // MAC 3*5 -> 15, latency 3 cycles
    expect_res(4'd1, 32'd15, 5'd10);
    issue(3'b000, 5'd10, 4'd1, 32'd3, 32'd5, 1'b1);
    @(negedge clk) chk("lat_t1", {31'd0, res_valid}, 32'd0);
    @(negedge clk) chk("lat_t2", {31'd0, res_valid}, 32'd0);
    @(negedge clk) chk("lat_t3", {31'd0, res_valid}, 32'd1);
    chk("acc_15", acc, 32'd15);
    drain();

    // Wraparound: CLRACC, acc=5, MAC 0xFFFFFFFF*2 -> 3, RDACC -> 3
    expect_res(4'd2, 32'd15, 5'd0);
    expect_res(4'd3, 32'd5, 5'd5);
    expect_res(4'd4, 32'd3, 5'd6);
    expect_res(4'd5, 32'd3, 5'd7);
    issue(3'b010, 5'd0, 4'd2, 32'd0, 32'd0, 1'b1);
    issue(3'b000, 5'd5, 4'd3, 32'd1, 32'd5, 1'b1);
    issue(3'b000, 5'd6, 4'd4, 32'hFFFF_FFFF, 32'd2, 1'b1);
    issue(3'b001, 5'd7, 4'd5, 32'd0, 32'd0, 1'b1);
    drain();
    chk("acc_wrap", acc, 32'd3);

    // Operands not ready: recognised word stalls
    @(posedge clk); #1;
    issue_instr = ins(3'b000, 5'd1); issue_rs_valid = 2'b01;
    #1 chk("ready_rs_invalid", {31'd0, issue_ready}, 32'd0);

    // Kill: ids 1..3, kill id 2
    issue(3'b000, 5'd1, 4'd1, 32'd2, 32'd3, 1'b0);
    issue(3'b000, 5'd2, 4'd2, 32'd4, 32'd5, 1'b0);
    issue(3'b000, 5'd3, 4'd3, 32'd7, 32'd1, 1'b0);
    expect_res(4'd1, 32'd9, 5'd1);
    commit(4'd1, 1'b0);
    commit(4'd2, 1'b1);
    expect_res(4'd3, 32'd16, 5'd3);
    commit(4'd3, 1'b0);
    drain();
    chk("acc_kill", acc, 32'd16);

    // Full queue
    for (int i = 4; i < 8; i++) issue(3'b000, 5'(i), 4'(i), 32'd1, 32'd1, 1'b0);
    @(posedge clk); #1;
    issue_instr = ins(3'b000, 5'd1); issue_rs_valid = 2'b11;
    #1 chk("full_ready_rec", {31'd0, issue_ready}, 32'd0);
    chk("full_accept_rec", {31'd0, issue_accept}, 32'd1);
    issue_instr = 32'h0000_0013;
    #1 chk("full_ready_unrec", {31'd0, issue_ready}, 32'd1);
    chk("full_accept_unrec", {31'd0, issue_accept}, 32'd0);
    chk("full_wb_unrec", {31'd0, issue_writeback}, 32'd0);
    issue_instr = ins(3'b000, 5'd1);
    expect_res(4'd4, 32'd17, 5'd4);
    commit(4'd4, 1'b0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("slot_freed", {31'd0, issue_ready}, 32'd1);
    expect_res(4'd5, 32'd18, 5'd5);
    expect_res(4'd6, 32'd19, 5'd6);
    expect_res(4'd7, 32'd20, 5'd7);
    commit(4'd5, 1'b0);
    commit(4'd6, 1'b0);
    commit(4'd7, 1'b0);
    drain();
    chk("acc_full", acc, 32'd20);

    // Backpressure for 10 cycles, then CLRACC
    rdy = 1'b0;
    expect_res(4'd8, 32'd24, 5'd8);
    issue(3'b000, 5'd8, 4'd8, 32'd2, 32'd2, 1'b1);
    for (int i = 0; i < 10 && !res_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_data", res_data, 32'd24);
      chk("hold_id", {28'd0, res_id}, 32'd8);
    end
    rdy = 1'b1;
    drain();
    expect_res(4'd9, 32'd24, 5'd9);
    issue(3'b010, 5'd9, 4'd9, 32'd0, 32'd0, 1'b1);
    drain();
    chk("acc_cleared", acc, 32'd0);

    // Reset during EXEC
    expect_res(4'd10, 32'd7, 5'd10);
    issue(3'b000, 5'd10, 4'd10, 32'd7, 32'd1, 1'b1);
    drain();
    chk("acc_7", acc, 32'd7);
    issue(3'b000, 5'd11, 4'd11, 32'd3, 32'd3, 1'b1);
    rst = 1'b1;
    #1 chk("rst_mid_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_mid_acc", acc, 32'd0);
    chk("rst_mid_data", res_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_valid", {31'd0, res_valid}, 32'd0);
    chk("post_rst_acc", acc, 32'd0);
    expect_res(4'd12, 32'd6, 5'd12);
    issue(3'b000, 5'd12, 4'd12, 32'd2, 32'd3, 1'b1);
    drain();
    chk("acc_final", acc, 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
